surf_event_merger: RTL and testbench



---
 rtl/surf_event_merger.sv | 157 +++++++++++++++
 tb/tb_surf_event_merger.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_event_merger.sv
`default_nettype none
// ============================================================================
// Module   : surf_event_merger
// Brief    : Frame-granular round-robin merger of seven SURF event byte streams
//            into one AXI4-Stream, with optional source header and truncation.
// Revision : 1.0
// ============================================================================
module surf_event_merger #(
    parameter int unsigned MAX_LEN = 1024,
    parameter bit          HEADER  = 1'b1
) (
    input  logic        sysclk_i,
    input  logic        rstn_i,
    input  logic [6:0]  enable_i,
    input  logic [55:0] s_dout_tdata,
    input  logic [6:0]  s_dout_tvalid,
    input  logic [6:0]  s_dout_tlast,
    output logic [6:0]  s_dout_tready,
    output logic [7:0]  m_ev_tdata,
    output logic        m_ev_tvalid,
    input  logic        m_ev_tready,
    output logic        m_ev_tlast,
    output logic [2:0]  m_ev_tuser,
    output logic        busy_o,
    output logic        trunc_o,
    output logic [15:0] trunc_count_o
);

    localparam logic [15:0] c_CNT_LAST = 16'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PASS  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [2:0]  r_ptr;
    logic [15:0] r_cnt;
    logic        r_trunc;
    logic [15:0] r_trunc_count;

    logic [6:0]  w_req;
    logic        w_hit;
    logic [2:0]  w_hit_idx;
    logic        w_sel_valid;
    logic        w_sel_last;
    logic [7:0]  w_sel_data;
    logic        w_cnt_end;

    // (base + off) mod 7 for base in 0..6, off in 1..7
    function automatic logic [2:0] f_wrap7(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] v_sum;
        v_sum = {1'b0, base} + {1'b0, off};
        return (v_sum >= 4'd7) ? 3'(v_sum - 4'd7) : v_sum[2:0];
    endfunction

    assign w_req       = enable_i & s_dout_tvalid;
    assign w_sel_valid = s_dout_tvalid[r_sel];
    assign w_sel_last  = s_dout_tlast[r_sel];
    assign w_sel_data  = s_dout_tdata[{r_sel, 3'b000} +: 8];
    assign w_cnt_end   = (r_cnt == c_CNT_LAST);

    // Search starts just after the last granted SURF so every source gets a turn
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            if (!w_hit && w_req[f_wrap7(r_ptr, 3'(k))]) begin
                w_hit     = 1'b1;
                w_hit_idx = f_wrap7(r_ptr, 3'(k));
            end
        end
    end

    always_comb begin
        s_dout_tready = ~enable_i;
        m_ev_tvalid   = 1'b0;
        m_ev_tdata    = 8'h00;
        m_ev_tlast    = 1'b0;
        case (r_state)
            ST_HDR: begin
                s_dout_tready[r_sel] = 1'b0;
                m_ev_tvalid          = 1'b1;
                m_ev_tdata           = 8'h80 | {5'd0, r_sel};
            end
            ST_PASS: begin
                s_dout_tready[r_sel] = m_ev_tready;
                m_ev_tvalid          = w_sel_valid;
                m_ev_tdata           = w_sel_data;
                m_ev_tlast           = w_sel_last | w_cnt_end;
            end
            ST_DRAIN: begin
                s_dout_tready[r_sel] = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_ev_tuser    = r_sel;
    assign busy_o        = (r_state != ST_IDLE);
    assign trunc_o       = r_trunc;
    assign trunc_count_o = r_trunc_count;

    always_ff @(posedge sysclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= ST_IDLE;
            r_sel         <= 3'd0;
            r_ptr         <= 3'd6;
            r_cnt         <= 16'd0;
            r_trunc       <= 1'b0;
            r_trunc_count <= 16'd0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_sel   <= w_hit_idx;
                        r_ptr   <= w_hit_idx;
                        r_cnt   <= 16'd0;
                        r_state <= HEADER ? ST_HDR : ST_PASS;
                    end
                end
                ST_HDR: begin
                    if (m_ev_tready) begin
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_sel_valid && m_ev_tready) begin
                        r_cnt <= r_cnt + 16'd1;
                        // A natural end of frame wins over the length limit
                        if (w_sel_last) begin
                            r_state <= ST_IDLE;
                        end else if (w_cnt_end) begin
                            r_trunc <= 1'b1;
                            if (r_trunc_count != 16'hFFFF) begin
                                r_trunc_count <= r_trunc_count + 16'd1;
                            end
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_surf_event_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_surf_event_merger
// Brief    : Directed vector bench for surf_event_merger (MAX_LEN=4, header on).
// Revision : 1.0
// ============================================================================
module tb_surf_event_merger;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [6:0]  enable_i;
    logic [55:0] s_tdata;
    logic [6:0]  s_tvalid;
    logic [6:0]  s_tlast;
    logic [6:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [2:0]  m_tuser;
    logic        busy;
    logic        trunc;
    logic [15:0] trunc_cnt;

    always #5 clk = ~clk;

    surf_event_merger #(.MAX_LEN(4), .HEADER(1'b1)) u_dut (
        .sysclk_i      (clk),
        .rstn_i        (rstn_i),
        .enable_i      (enable_i),
        .s_dout_tdata  (s_tdata),
        .s_dout_tvalid (s_tvalid),
        .s_dout_tlast  (s_tlast),
        .s_dout_tready (s_tready),
        .m_ev_tdata    (m_tdata),
        .m_ev_tvalid   (m_tvalid),
        .m_ev_tready   (m_tready),
        .m_ev_tlast    (m_tlast),
        .m_ev_tuser    (m_tuser),
        .busy_o        (busy),
        .trunc_o       (trunc),
        .trunc_count_o (trunc_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  vld;
        logic [55:0] data;
        logic [6:0]  last;
        logic        e_v;
        logic [7:0]  e_d;
        logic        e_l;
        logic [2:0]  e_u;
        logic [6:0]  e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [55:0] byte_at(input int n, input logic [7:0] v);
        logic [55:0] r;
        r = '0;
        r[8*n +: 8] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [6:0] vld, input logic [55:0] d, input logic [6:0] l,
                                input logic e_v, input logic [7:0] e_d, input logic e_l,
                                input logic [2:0] e_u, input logic [6:0] e_rdy, input logic e_b);
        vec_t r;
        r.vld = vld; r.data = d; r.last = l;
        r.e_v = e_v; r.e_d = e_d; r.e_l = e_l; r.e_u = e_u; r.e_rdy = e_rdy; r.e_busy = e_b;
        return r;
    endfunction

    // Behavioural sources: SURF s sends frames of src_len bytes, byte i = 16*s + i
    int          src_len[7];
    int          src_pos[7];
    int          src_frames[7];
    logic [11:0] outq[$];
    logic [3:0]  mr_pattern = 4'b1111;
    int          cyc_n = 0;
    int          trunc_pulses = 0;
    int          rdy5_bad = 0;
    int          stall_bad = 0;
    int          mirror_bad = 0;
    logic        chk_rdy5 = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'h00;

    task automatic src_set(input int s, input int len, input int frames);
        src_len[s] = len; src_pos[s] = 0; src_frames[s] = frames;
    endtask

    task automatic run(input int n);
        logic [6:0] fire;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int s = 0; s < 7; s++) begin
                s_tvalid[s]       = (src_frames[s] > 0);
                s_tlast[s]        = (src_pos[s] == src_len[s] - 1);
                s_tdata[8*s +: 8] = 8'(16*s + src_pos[s]);
            end
            m_tready = mr_pattern[cyc_n % 4];
            cyc_n++;
            #1;
            if (m_tvalid && m_tready) outq.push_back({m_tuser, m_tlast, m_tdata});
            if (trunc) trunc_pulses++;
            if (chk_rdy5 && !s_tready[5]) rdy5_bad++;
            if (prev_stall && !(m_tvalid && m_tdata == prev_d)) stall_bad++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            if (busy && ((s_tvalid[m_tuser] && s_tready[m_tuser]) !== (m_tvalid && m_tready && !m_tdata[7])))
                mirror_bad++;
            fire = s_tvalid & s_tready;
            @(posedge clk);
            for (int s = 0; s < 7; s++) begin
                if (fire[s]) begin
                    if (src_pos[s] == src_len[s] - 1) begin
                        src_pos[s] = 0;
                        src_frames[s]--;
                    end else begin
                        src_pos[s]++;
                    end
                end
            end
        end
    endtask

    task automatic expect_frame(input string tag, input int s, input int nb);
        logic [11:0] got;
        logic [11:0] exp;
        for (int i = -1; i < nb; i++) begin
            if (i < 0) exp = {3'(s), 1'b0, 8'(8'h80 | s)};
            else       exp = {3'(s), 1'(i == nb - 1), 8'(16*s + i)};
            if (outq.size() == 0) got = 12'hFFF;
            else                  got = outq.pop_front();
            check($sformatf("%s.beat%0d", tag, i + 1), got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn_i   = 1'b0;
        s_tvalid = '0;
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i   = 1'b0;
        enable_i = 7'b0000100;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int s = 0; s < 7; s++) src_set(s, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        check("rst.tvalid", m_tvalid, 1'b0);
        check("rst.tdata", m_tdata, 8'h00);
        check("rst.tlast", m_tlast, 1'b0);
        check("rst.tuser", m_tuser, 3'd0);
        check("rst.busy", busy, 1'b0);
        check("rst.trunc_cnt", trunc_cnt, 16'd0);
        check("rst.s_tready", s_tready, 7'b1111011);
        @(negedge clk);
        rstn_i = 1'b1;

        // Single source on SURF 2, then a second 1-byte frame right after the idle cycle
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h11), 7'b0, 0, 8'h00, 0, 3'd0, 7'b1111011, 0));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h11), 7'b0, 1, 8'h82, 0, 3'd2, 7'b1111011, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h11), 7'b0, 1, 8'h11, 0, 3'd2, 7'b1111111, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h22), 7'b0, 1, 8'h22, 0, 3'd2, 7'b1111111, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h33), 7'b0, 1, 8'h33, 0, 3'd2, 7'b1111111, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h44), 7'b0000100, 1, 8'h44, 1, 3'd2, 7'b1111111, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h55), 7'b0000100, 0, 8'h00, 0, 3'd2, 7'b1111011, 0));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h55), 7'b0000100, 1, 8'h82, 0, 3'd2, 7'b1111011, 1));
        vecs.push_back(mk(7'b0000100, byte_at(2, 8'h55), 7'b0000100, 1, 8'h55, 1, 3'd2, 7'b1111111, 1));
        vecs.push_back(mk(7'b0000000, byte_at(2, 8'h00), 7'b0, 0, 8'h00, 0, 3'd2, 7'b1111011, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            s_tvalid = vecs[i].vld;
            s_tdata  = vecs[i].data;
            s_tlast  = vecs[i].last;
            m_tready = 1'b1;
            #1;
            check($sformatf("v%0d.tvalid", i), m_tvalid, vecs[i].e_v);
            if (vecs[i].e_v) begin
                check($sformatf("v%0d.tdata", i), m_tdata, vecs[i].e_d);
                check($sformatf("v%0d.tlast", i), m_tlast, vecs[i].e_l);
            end
            check($sformatf("v%0d.tuser", i), m_tuser, vecs[i].e_u);
            check($sformatf("v%0d.s_tready", i), s_tready, vecs[i].e_rdy);
            check($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
        end

        // Round robin over SURFs 0, 3, 6 from reset
        do_reset();
        enable_i = 7'b1001001;
        src_set(0, 2, 2); src_set(3, 2, 2); src_set(6, 2, 2);
        outq.delete();
        run(30);
        expect_frame("rr0", 0, 2); expect_frame("rr1", 3, 2); expect_frame("rr2", 6, 2);
        expect_frame("rr3", 0, 2); expect_frame("rr4", 3, 2); expect_frame("rr5", 6, 2);
        check("rr.extra", outq.size(), 0);

        // Truncation of a 6-byte frame, then an exact 4-byte frame
        enable_i     = 7'b0000010;
        trunc_pulses = 0;
        src_set(1, 6, 1);
        run(14);
        check("tr.count1", trunc_cnt, 16'd1);
        check("tr.drained", src_frames[1], 0);
        src_set(1, 4, 1);
        run(10);
        expect_frame("tr_long", 1, 4);
        expect_frame("tr_exact", 1, 4);
        check("tr.extra", outq.size(), 0);
        check("tr.pulses", trunc_pulses, 1);
        check("tr.count2", trunc_cnt, 16'd1);

        // SURF 5 disabled and streaming; SURF 4 loses its enable mid-frame
        enable_i = 7'b0010000;
        chk_rdy5 = 1'b1;
        src_set(5, 4, 1000);
        src_set(4, 4, 1);
        run(3);
        enable_i = 7'b0000000;
        run(10);
        expect_frame("dis", 4, 4);
        check("dis.extra", outq.size(), 0);
        check("dis.rdy5_bad", rdy5_bad, 0);
        check("dis.s5_consumed", src_frames[5] < 1000, 1'b1);
        chk_rdy5 = 1'b0;
        src_frames[5] = 0;
        run(2);

        // Backpressure 1,0,0,1 through header and payload
        enable_i   = 7'b0001000;
        src_set(3, 3, 1);
        mr_pattern = 4'b1001;
        cyc_n      = 0;
        prev_stall = 1'b0;
        stall_bad  = 0;
        mirror_bad = 0;
        outq.delete();
        run(20);
        expect_frame("bp", 3, 3);
        check("bp.extra", outq.size(), 0);
        check("bp.stall_bad", stall_bad, 0);
        check("bp.mirror_bad", mirror_bad, 0);
        mr_pattern = 4'b1111;

        // Reset mid-PASS on SURF 2, then SURF 2 and 4 both pending
        enable_i = 7'b0000100;
        src_set(2, 4, 1);
        run(4);
        #2;
        check("rst2.pre_busy", busy, 1'b1);
        enable_i = 7'b0010100;
        rstn_i   = 1'b0;
        #1;
        check("rst2.tvalid", m_tvalid, 1'b0);
        check("rst2.tlast", m_tlast, 1'b0);
        check("rst2.tdata", m_tdata, 8'h00);
        check("rst2.tuser", m_tuser, 3'd0);
        check("rst2.busy", busy, 1'b0);
        check("rst2.trunc_cnt", trunc_cnt, 16'd0);
        check("rst2.s_tready", s_tready, 7'b1101011);
        src_set(2, 4, 1);
        src_set(4, 4, 1);
        @(negedge clk);
        rstn_i = 1'b1;
        outq.delete();
        run(16);
        expect_frame("rst2.first", 2, 4);
        expect_frame("rst2.second", 4, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
